// File: rtl/atributos_pkg.sv
// Shared constants for the pet attribute controller: activity-state encodings and
// default tuning values.
package atributos_pkg;

    localparam logic [2:0] ESTADO_IDLE       = 3'b000;
    localparam logic [2:0] ESTADO_DORMINDO   = 3'b001;
    localparam logic [2:0] ESTADO_COMENDO    = 3'b010;
    localparam logic [2:0] ESTADO_DANDO_AULA = 3'b011;

    localparam int unsigned DEF_TICKS_PER_SEC = 100;
    localparam int unsigned DEF_MAX_VAL       = 100;
    localparam int unsigned DEF_INIT_VAL      = 50;
    localparam int unsigned DEF_INC_STEP      = 5;
    localparam int unsigned DEF_DEC_STEP      = 1;

endpackage

// File: rtl/controlador_atributos_if.sv
// Activity-state input and attribute-level outputs shared between the activity FSM
// (master) and the attribute controller (slave).
interface controlador_atributos_if;

    logic [2:0] estado;
    logic [7:0] fome;
    logic [7:0] felicidade;
    logic [7:0] sono;
    logic       morreu;

    modport master (
        output estado,
        input  fome,
        input  felicidade,
        input  sono,
        input  morreu
    );

    modport slave (
        input  estado,
        output fome,
        output felicidade,
        output sono,
        output morreu
    );

endinterface

// File: rtl/gerador_tick.sv
// One-cycle pulse every TICKS_PER_SEC clocks; the pulse is high while the free-running
// counter sits at its terminal count.
module gerador_tick
    import atributos_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICKS_PER_SEC - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        tick    = (count_q == CntLast);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/controlador_atributos.sv
// Pet attribute controller: once per tick raises the level tied to the current activity
// and decays the others, saturating at 0..MAX_VAL, with a sticky death flag.
module controlador_atributos
    import atributos_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned MAX_VAL       = DEF_MAX_VAL,
    parameter int unsigned INIT_VAL      = DEF_INIT_VAL,
    parameter int unsigned INC_STEP      = DEF_INC_STEP,
    parameter int unsigned DEC_STEP      = DEF_DEC_STEP
) (
    input  logic                    clk,
    input  logic                    reset,
    controlador_atributos_if.slave  bus
);

    logic       tick;
    logic [7:0] fome_q, fome_d;
    logic [7:0] felicidade_q, felicidade_d;
    logic [7:0] sono_q, sono_d;
    logic       morreu_q, morreu_d;

    gerador_tick #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_gerador_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // 9-bit sum so the clamp sees the true result before truncation.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [8:0] sum;
        sum = {1'b0, v} + 9'(INC_STEP);
        return (sum > 9'(MAX_VAL)) ? 8'(MAX_VAL) : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v < 8'(DEC_STEP)) ? 8'd0 : v - 8'(DEC_STEP);
    endfunction

    always_comb begin
        fome_d       = fome_q;
        felicidade_d = felicidade_q;
        sono_d       = sono_q;
        morreu_d     = morreu_q;
        if (tick && !morreu_q) begin
            fome_d       = sat_dec(fome_q);
            felicidade_d = sat_dec(felicidade_q);
            sono_d       = sat_dec(sono_q);
            case (bus.estado)
                ESTADO_DORMINDO:   sono_d       = sat_inc(sono_q);
                ESTADO_COMENDO:    fome_d       = sat_inc(fome_q);
                ESTADO_DANDO_AULA: felicidade_d = sat_inc(felicidade_q);
                default:           ;
            endcase
            morreu_d = (fome_d == 8'd0) || (felicidade_d == 8'd0) || (sono_d == 8'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fome_q       <= 8'(INIT_VAL);
            felicidade_q <= 8'(INIT_VAL);
            sono_q       <= 8'(INIT_VAL);
            morreu_q     <= 1'b0;
        end else begin
            fome_q       <= fome_d;
            felicidade_q <= felicidade_d;
            sono_q       <= sono_d;
            morreu_q     <= morreu_d;
        end
    end

    assign bus.fome       = fome_q;
    assign bus.felicidade = felicidade_q;
    assign bus.sono       = sono_q;
    assign bus.morreu     = morreu_q;

endmodule

// File: tb/tb_controlador_atributos.sv
// Directed bench for controlador_atributos: table of {estado, ticks, expected levels}
// plus hand sequences for async reset and mid-period estado changes.
module tb_controlador_atributos;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    controlador_atributos_if bus ();

    controlador_atributos u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        logic [2:0] estado;
        int         nticks;
        int         e_fome;
        int         e_fel;
        int         e_sono;
        int         e_morreu;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic check_all(input string tag, input int f, input int fe, input int s,
                             input int m);
        check({tag, " fome"}, int'(bus.fome), f);
        check({tag, " felicidade"}, int'(bus.felicidade), fe);
        check({tag, " sono"}, int'(bus.sono), s);
        check({tag, " morreu"}, int'(bus.morreu), m);
    endtask

    // Reset asserted and released on falling edges so the tick phase stays known.
    task automatic pulse_reset(input logic [2:0] est);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.estado = est;
        reset = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus.estado = 3'b000;

        vecs[0] = '{1'b0, 3'b000, 2,  47, 47,  47, 0};
        vecs[1] = '{1'b0, 3'b001, 3,  44, 44,  62, 0};
        vecs[2] = '{1'b0, 3'b010, 3,  59, 41,  59, 0};
        vecs[3] = '{1'b0, 3'b011, 1,  58, 46,  58, 0};
        vecs[4] = '{1'b0, 3'b101, 1,  57, 45,  57, 0};
        vecs[5] = '{1'b1, 3'b011, 12, 38, 100, 38, 0};
        vecs[6] = '{1'b0, 3'b111, 1,  37, 99,  37, 0};
        vecs[7] = '{1'b1, 3'b000, 49, 1,  1,   1,  0};
        vecs[8] = '{1'b0, 3'b000, 1,  0,  0,   0,  1};
        vecs[9] = '{1'b0, 3'b010, 5,  0,  0,   0,  1};

        @(negedge clk);
        check_all("reset", 50, 50, 50, 0);
        @(negedge clk);
        reset = 1'b0;

        // First update lands exactly on the 100th edge after release.
        run_cycles(99);
        check_all("pre_tick", 50, 50, 50, 0);
        run_cycles(1);
        check_all("first_tick", 49, 49, 49, 0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_rst) pulse_reset(vecs[i].estado);
            else bus.estado = vecs[i].estado;
            run_cycles(vecs[i].nticks * 100);
            check_all($sformatf("vec%0d", i), vecs[i].e_fome, vecs[i].e_fel,
                      vecs[i].e_sono, vecs[i].e_morreu);
        end

        // Async reset mid-period while dead: outputs restore before any clk edge.
        run_cycles(37);
        #2 reset = 1'b1;
        #1 check_all("async_rst", 50, 50, 50, 0);
        @(negedge clk);
        bus.estado = 3'b001;
        reset = 1'b0;
        run_cycles(99);
        check_all("post_rst_pre", 50, 50, 50, 0);
        run_cycles(1);
        check_all("post_rst_tick", 49, 49, 55, 0);

        // Only the estado present at the tick edge matters.
        bus.estado = 3'b010;
        repeat (30) @(negedge clk);
        bus.estado = 3'b011;
        repeat (30) @(negedge clk);
        bus.estado = 3'b110;
        repeat (30) @(negedge clk);
        bus.estado = 3'b000;
        repeat (8) @(negedge clk);
        check_all("toggle_hold", 49, 49, 55, 0);
        bus.estado = 3'b001;
        repeat (2) @(negedge clk);
        check_all("toggle_tick", 48, 48, 60, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
